ms_wb_master: RTL

MS_WB_MASTER -- requirements
Module: ms_wb_master

---
 rtl/ms_wb_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ms_wb_master.sv
// Wishbone classic initiator driven by a simple command/response port.
// Each command runs a single read or write bus cycle. A read can instead poll:
// it repeats until the masked read data is nonzero, with an idle gap between
// attempts. A bus cycle that gets no ack is aborted after a timeout.
// POLL_GAP is expected to be at least 1. TIMEOUT_CYCLES is expected to be at least 1.
module ms_wb_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int POLL_GAP       = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic        cmd_poll_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_mask_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    logic [1:0]       state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      mask_q;
    logic             poll_q;
    logic             cyc_q;

    logic accept;
    logic bus_ack;
    logic bus_tmo;
    logic poll_miss;
    logic gap_done;
    logic finish;

    assign cmd_ready_o = (state == ST_IDLE);
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;

    // Decode this cycle's events. An ack on the timeout edge counts as an ack. A poll miss is an acked poll read whose masked data is zero.
    always_comb begin
        accept    = cmd_valid_i & cmd_ready_o;
        bus_ack   = (state == ST_BUS) & ack_i;
        bus_tmo   = (state == ST_BUS) & ~ack_i & (tmo_cnt == TMO_LAST);
        poll_miss = bus_ack & poll_q & ((dat_i & mask_q) == 32'd0);
        gap_done  = (state == ST_GAP) & (gap_cnt == GAP_LAST);
        finish    = (bus_ack & ~poll_miss) | bus_tmo;
    end

    // Main sequencer: IDLE -> BUS -> (GAP -> BUS)* -> RESP -> IDLE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= ST_BUS;
                ST_BUS: begin
                    if (poll_miss)   state <= ST_GAP;
                    else if (finish) state <= ST_RESP;
                end
                ST_GAP:  if (gap_done) state <= ST_BUS;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The timeout counter restarts on every entry into BUS. The gap counter restarts on every poll miss.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept || gap_done)  tmo_cnt <= '0;
            else if (state == ST_BUS) tmo_cnt <= tmo_cnt + 1'b1;

            if (poll_miss)            gap_cnt <= '0;
            else if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Latch the command onto the bus. Address, data, select and we hold their values between bus cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            adr_o  <= '0;
            dat_o  <= '0;
            sel_o  <= '0;
            we_o   <= 1'b0;
            mask_q <= '0;
            poll_q <= 1'b0;
            cyc_q  <= 1'b0;
        end else begin
            if (accept) begin
                adr_o  <= cmd_adr_i;
                dat_o  <= cmd_dat_i;
                sel_o  <= cmd_sel_i;
                we_o   <= cmd_we_i;
                mask_q <= cmd_mask_i;
                poll_q <= cmd_poll_i & ~cmd_we_i & (cmd_mask_i != 32'd0);
            end
            if (accept || gap_done)     cyc_q <= 1'b1;
            else if (bus_ack || bus_tmo) cyc_q <= 1'b0;
        end
    end

    // Issue the response pulse. Read data is captured there and held until the next response. Writes and timeouts return zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            rsp_valid_o <= finish;
            rsp_err_o   <= bus_tmo;
            if (finish) rsp_dat_o <= (bus_ack && !we_o) ? dat_i : 32'd0;
        end
    end

endmodule
